// File: rtl/io_bridge_pkg.sv
// Shared constants for io_bridge: IO address map and the hex-to-seven-segment table.
package io_bridge_pkg;

  localparam logic [31:0] IO_BASE      = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DISP    = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TMR_VAL = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TMR_DIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED     = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW      = 32'hFFFF_F070;

  // Active-low {DP,G,F,E,D,C,B,A}; DP bit is always 1 (off). Entry 0 is the low byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/io_bridge_seg_scan.sv
// Multiplexed 8-digit display scan: slot counter, digit index and segment decode.
module seg_scan
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp,
  output logic [7:0]  dig_en_n,
  output logic [7:0]  seg_n
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decode straight from the live display register so a write shows up without a scan restart.
  assign dig_en_n = ~(8'd1 << idx);
  assign seg_n    = hex_to_seg(disp[{idx, 2'b00} +: 4]);

endmodule

// File: rtl/io_bridge.sv
// CPU bus bridge: DRAM pass-through, memory-mapped display/LED/switch registers and
// an optional free-running timer (enabled by defining IO_BRIDGE_TIMER_EN).
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DRAM_AW  = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         dig_en_n,
  output logic [7:0]         seg_n
);

  logic        io_hit;
  logic        wr_io;
  logic [31:0] disp_q;
  logic [23:0] led_q;
  logic [23:0] sw_s1, sw_s2;

  assign io_hit     = (Bus_addr[31:12] == IO_BASE[31:12]);
  assign wr_io      = Bus_wen & io_hit;
  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_we    = Bus_wen & ~io_hit;
  assign led        = led_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      disp_q <= '0;
      led_q  <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (wr_io && Bus_addr == ADDR_DISP) disp_q <= Bus_wdata;
      if (wr_io && Bus_addr == ADDR_LED)  led_q  <= Bus_wdata[23:0];
    end
  end

`ifdef IO_BRIDGE_TIMER_EN
  logic [31:0] tmr_val, tmr_div, tmr_pre;
  logic        tmr_tick;

  assign tmr_tick = (tmr_div != '0) && (tmr_pre == tmr_div - 32'd1);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      tmr_val <= '0;
      tmr_div <= '0;
      tmr_pre <= '0;
    end else begin
      if (wr_io && Bus_addr == ADDR_TMR_DIV) begin
        tmr_div <= Bus_wdata;
        tmr_pre <= '0;
      end else if (tmr_tick || tmr_div == '0) begin
        tmr_pre <= '0;
      end else begin
        tmr_pre <= tmr_pre + 32'd1;
      end
      // A software load beats a coincident tick.
      if (wr_io && Bus_addr == ADDR_TMR_VAL) tmr_val <= Bus_wdata;
      else if (tmr_tick)                     tmr_val <= tmr_val + 32'd1;
    end
  end
`endif

  always_comb begin
    Bus_rdata = '0;
    if (!io_hit) begin
      Bus_rdata = dram_rdata;
    end else begin
      case (Bus_addr)
        ADDR_DISP:    Bus_rdata = disp_q;
`ifdef IO_BRIDGE_TIMER_EN
        ADDR_TMR_VAL: Bus_rdata = tmr_val;
        ADDR_TMR_DIV: Bus_rdata = tmr_div;
`endif
        ADDR_LED:     Bus_rdata = {8'h00, led_q};
        ADDR_SW:      Bus_rdata = {8'h00, sw_s2};
        default:      Bus_rdata = '0;
      endcase
    end
  end

  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_seg_scan (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .disp     (disp_q),
    .dig_en_n (dig_en_n),
    .seg_n    (seg_n)
  );

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter DRAM_AW, default 14: DRAM word-address width.
REQ-002 Parameter SCAN_DIV, default 50000: cpu_clk cycles per display digit slot; legal range 2..2^20.
REQ-003 Port cpu_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port cpu_rst  input  1  reset, asynchronous, active-high.
REQ-005 Port Bus_addr  input  32  byte address from the CPU MEM stage.
REQ-006 Port Bus_wen  input  1  CPU store strobe.
REQ-007 Port Bus_wdata  input  32  CPU store data.
REQ-008 Port Bus_rdata  output  32  load data returned to the CPU.
REQ-009 Port dram_addr  output  DRAM_AW  DRAM word address.
REQ-010 Port dram_we  output  1  DRAM write enable.
REQ-011 Port dram_wdata  output  32  DRAM write data.
REQ-012 Port dram_rdata  input  32  DRAM asynchronous read data.
REQ-013 Port sw  input  24  raw board switches.
REQ-014 Port led  output  24  board LEDs, active-high.
REQ-015 Port dig_en_n  output  8  digit enables, active-low.
REQ-016 Port seg_n  output  8  segments {DP,G,F,E,D,C,B,A}, active-low.

Function
REQ-017 Address map: 0xFFFF_F000 display data (8 hex nibbles, nibble k = digit k); 0xFFFF_F020 timer value; 0xFFFF_F024 timer divisor; 0xFFFF_F060 LED register; 0xFFFF_F070 switches (read-only); other 0xFFFF_Fxxx addresses are unmapped IO; all addresses below 0xFFFF_F000 are DRAM.
REQ-018 dram_addr = Bus_addr[DRAM_AW+1:2]; dram_wdata = Bus_wdata; dram_we = Bus_wen AND DRAM hit, combinational.
REQ-019 Bus_rdata is combinational, zero-latency: DRAM hit returns dram_rdata; IO register hit returns the register (LED zero-extended, switches zero-extended); unmapped IO returns 0.
REQ-020 Writes to IO registers take effect at the rising edge where Bus_wen is high; never assert dram_we; writes to switches or unmapped IO are ignored.
REQ-021 Switches pass through a two-flop synchronizer; reads return the second stage, so a switch change is visible 2 cycles later.
REQ-022 Scan: counter 0..SCAN_DIV-1; at terminal count it wraps to 0 and digit index advances 0,1,...,7,0.
REQ-023 dig_en_n has only bit [index] low; seg_n = hex-to-segment code of display nibble [index], DP always off.
REQ-024 A display write mid-slot updates seg_n on the next cycle without restarting the scan.
REQ-025 Timer: prescaler counts 0..divisor-1; at terminal count timer value increments by 1, wrapping 0xFFFF_FFFF to 0.
REQ-026 Divisor 0 halts the timer and holds the prescaler at 0; writing the divisor clears the prescaler.
REQ-027 A timer-value write coinciding with a tick loads Bus_wdata; the write wins and the prescaler clears.

Reset
REQ-028 Reset clears display, LED, timer value, divisor, prescaler, scan counter, digit index and synchronizer flops.
REQ-029 During reset: led = 0, dig_en_n = 8'hFE, seg_n = 8'hC0; Bus_rdata and dram_* remain combinational.
REQ-030 Reset asserted mid-scan or mid-count returns all state to reset values immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro IO_BRIDGE_TIMER_EN defined: timer per REQ-025..027.
REQ-032 Macro undefined: no timer logic; timer addresses read 0; writes to them are ignored; they are not forwarded to DRAM.

Structure
REQ-033 Shared package io_bridge_pkg holds the IO address constants, the IO base 0xFFFF_F000 and the 16-entry hex-to-segment table.
REQ-034 Sub-module seg_scan holds the scan counter, digit index and segment decode; io_bridge holds decode, registers, synchronizer and timer.

Verification
REQ-035 Reset, then release: led = 0, dig_en_n = 8'hFE, seg_n = 8'hC0.
REQ-036 Store 0x0000_0010 = 0xDEADBEEF, then load 0x0000_0010: dram_we pulses once with dram_addr = 4, and Bus_rdata = 0xDEADBEEF.
REQ-037 Store 0xFFFF_F060 = 0x00A5A5A5, then load: led = 0xA5A5A5 next cycle, dram_we stays 0, and readback is 0x00A5A5A5.
REQ-038 SCAN_DIV = 4, display = 0x76543210: dig_en_n steps FE, FD, ..., 7F, FE, one step every 4 cycles; seg_n = C0 on digit 0 and F9 on digit 1.
REQ-039 With the timer macro defined, divisor = 3 and value = 0xFFFF_FFFF: value reads 0 after 3 cycles; a value write of 5 on the tick cycle reads 5.
REQ-040 Switch toggles to 0x123456: a read at 0xFFFF_F070 returns 0x00123456 from the second cycle after the toggle, and the old value before that.
